// File: rtl/cpu15_pkg.sv
// Shared definitions for the 15-bit CPU: fetch state encoding and default geometry.
package cpu15_pkg;

    localparam int             CPU_PC_WIDTH     = 8;
    localparam int             CPU_INSTR_WIDTH  = 15;
    localparam logic [7:0]     CPU_RESET_VECTOR = 8'h00;
    localparam int             CPU_PROM_LATENCY = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALTED = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/fetch_seq_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module fetch_seq_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: owns the PC, waits out ROM read latency,
// captures the instruction and retires it on the execute-done handshake.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | waiting for RUN_EN
// ST_FETCH  | P_COUNT stable, counting out ROM read latency
// ST_LOAD   | PROM_OUT valid, captured into IR
// ST_EXEC   | IR held for execute stage, waiting for EX_DONE
// ST_HALTED | stopped after a halting instruction, exits only via RESET
module fetch_seq
    import cpu15_pkg::*;
#(
    parameter int                    PC_WIDTH     = CPU_PC_WIDTH,
    parameter int                    INSTR_WIDTH  = CPU_INSTR_WIDTH,
    parameter logic [PC_WIDTH-1:0]   RESET_VECTOR = PC_WIDTH'(CPU_RESET_VECTOR),
    parameter int                    PROM_LATENCY = CPU_PROM_LATENCY
) (
    input  logic                   CLK_FT,
    input  logic                   RESET,
    input  logic                   RUN_EN,
    input  logic [INSTR_WIDTH-1:0] PROM_OUT,
    input  logic                   EX_DONE,
    input  logic                   BRANCH_TAKEN,
    input  logic [PC_WIDTH-1:0]    BRANCH_ADDR,
    input  logic                   HALT_REQ,
    output logic [PC_WIDTH-1:0]    P_COUNT,
    output logic [INSTR_WIDTH-1:0] IR,
    output logic                   IR_VALID,
    output logic                   HALTED,
    output logic [15:0]            INSTR_CNT
);

    localparam int LAT_W = 2;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(PROM_LATENCY - 1);

    fetch_state_t          state, state_nxt;
    logic [LAT_W-1:0]      lat_cnt, lat_nxt;
    logic [PC_WIDTH-1:0]   pc_nxt;
    logic                  ir_load;
    logic                  retire;

    always_ff @(posedge CLK_FT) begin
        if (RESET) begin
            state    <= ST_IDLE;
            lat_cnt  <= '0;
            P_COUNT  <= RESET_VECTOR;
            IR       <= '0;
            IR_VALID <= 1'b0;
        end else begin
            state    <= state_nxt;
            lat_cnt  <= lat_nxt;
            P_COUNT  <= pc_nxt;
            IR_VALID <= ir_load;
            if (ir_load) begin
                IR <= PROM_OUT;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        lat_nxt   = lat_cnt;
        pc_nxt    = P_COUNT;
        ir_load   = 1'b0;
        retire    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (RUN_EN) begin
                    state_nxt = ST_FETCH;
                    lat_nxt   = '0;
                end
            end
            ST_FETCH: begin
                lat_nxt = lat_cnt + 1'b1;
                if (lat_cnt == LAT_LAST) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                ir_load   = 1'b1;
                state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                if (EX_DONE) begin
                    retire  = 1'b1;
                    lat_nxt = '0;
                    // Halt wins over branch; PC stays on the halting instruction.
                    if (HALT_REQ) begin
                        state_nxt = ST_HALTED;
                    end else if (BRANCH_TAKEN) begin
                        pc_nxt    = BRANCH_ADDR;
                        state_nxt = ST_FETCH;
                    end else begin
                        pc_nxt    = P_COUNT + 1'b1;
                        state_nxt = ST_FETCH;
                    end
                end
            end
            ST_HALTED: begin
                state_nxt = ST_HALTED;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign HALTED = (state == ST_HALTED);

    fetch_seq_sat_counter #(.W(16)) u_instr_cnt (
        .clk (CLK_FT),
        .rst (RESET),
        .inc (retire),
        .cnt (INSTR_CNT)
    );

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq with a one-cycle registered ROM model.
module tb_fetch_seq;

    logic        clk_ft = 1'b0;
    logic        reset;
    logic        run_en;
    logic [14:0] prom_out;
    logic        ex_done;
    logic        branch_taken;
    logic [7:0]  branch_addr;
    logic        halt_req;
    logic [7:0]  p_count;
    logic [14:0] ir;
    logic        ir_valid;
    logic        halted;
    logic [15:0] instr_cnt;

    logic [14:0] rom [256];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk_ft = ~clk_ft;

    always @(posedge clk_ft) prom_out <= rom[p_count];

    fetch_seq dut (
        .CLK_FT       (clk_ft),
        .RESET        (reset),
        .RUN_EN       (run_en),
        .PROM_OUT     (prom_out),
        .EX_DONE      (ex_done),
        .BRANCH_TAKEN (branch_taken),
        .BRANCH_ADDR  (branch_addr),
        .HALT_REQ     (halt_req),
        .P_COUNT      (p_count),
        .IR           (ir),
        .IR_VALID     (ir_valid),
        .HALTED       (halted),
        .INSTR_CNT    (instr_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_ft);
        #1;
    endtask

    // Two cycles with PROM_LATENCY=1: FETCH then LOAD, leaving the DUT in EXEC.
    task automatic fetch_in();
        tick();
        tick();
    endtask

    task automatic retire(input logic br, input logic [7:0] addr, input logic hlt);
        ex_done      = 1'b1;
        branch_taken = br;
        branch_addr  = addr;
        halt_req     = hlt;
        tick();
        ex_done      = 1'b0;
        branch_taken = 1'b0;
        halt_req     = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 15'((i * 37 + 5) ^ 'h2A00);
        rom[0] = 15'h1234;
        rom[1] = 15'h0ABC;
        reset = 1'b1; run_en = 1'b0; ex_done = 1'b0;
        branch_taken = 1'b0; branch_addr = 8'h00; halt_req = 1'b0;

        tick();
        chk("rst_pc",    32'(p_count),   32'h00);
        chk("rst_ir",    32'(ir),        32'h0);
        chk("rst_valid", 32'(ir_valid),  32'h0);
        chk("rst_halt",  32'(halted),    32'h0);
        chk("rst_cnt",   32'(instr_cnt), 32'h0);

        // Back-to-back execution with EX_DONE held high.
        reset = 1'b0; run_en = 1'b1; ex_done = 1'b1;
        tick();
        run_en = 1'b0;
        chk("c1_pc",    32'(p_count),  32'h00);
        chk("c1_valid", 32'(ir_valid), 32'h0);
        tick();
        chk("c2_pc",    32'(p_count),  32'h00);
        chk("c2_valid", 32'(ir_valid), 32'h0);
        tick();
        chk("c3_ir",    32'(ir),        32'h1234);
        chk("c3_valid", 32'(ir_valid),  32'h1);
        chk("c3_cnt",   32'(instr_cnt), 32'h0);
        tick();
        chk("c4_pc",    32'(p_count),   32'h01);
        chk("c4_valid", 32'(ir_valid),  32'h0);
        chk("c4_cnt",   32'(instr_cnt), 32'h1);
        chk("c4_ir",    32'(ir),        32'h1234);
        ex_done = 1'b0;
        fetch_in();
        chk("c6_ir",    32'(ir),       32'h0ABC);
        chk("c6_valid", 32'(ir_valid), 32'h1);
        tick();
        chk("wait_valid", 32'(ir_valid),  32'h0);
        chk("wait_pc",    32'(p_count),   32'h01);
        chk("wait_cnt",   32'(instr_cnt), 32'h1);

        // Branches: 01 -> 05 -> 10.
        retire(1'b1, 8'h05, 1'b0);
        chk("br5_pc", 32'(p_count), 32'h05);
        fetch_in();
        chk("br5_ir", 32'(ir), 32'(rom[5]));
        retire(1'b1, 8'h10, 1'b0);
        chk("br10_pc",  32'(p_count),   32'h10);
        chk("br10_cnt", 32'(instr_cnt), 32'h3);

        // EX_DONE during FETCH and LOAD must be ignored.
        ex_done = 1'b1; branch_taken = 1'b1; branch_addr = 8'h77;
        tick();
        chk("exf_pc", 32'(p_count), 32'h10);
        tick();
        ex_done = 1'b0; branch_taken = 1'b0;
        chk("exl_pc",  32'(p_count),   32'h10);
        chk("exl_ir",  32'(ir),        32'(rom[16]));
        chk("exl_cnt", 32'(instr_cnt), 32'h3);

        // PC wrap from FF to 00.
        retire(1'b1, 8'hFF, 1'b0);
        chk("ff_pc", 32'(p_count), 32'hFF);
        fetch_in();
        chk("ff_ir", 32'(ir), 32'(rom[255]));
        retire(1'b0, 8'h00, 1'b0);
        chk("wrap_pc",  32'(p_count),   32'h00);
        chk("wrap_cnt", 32'(instr_cnt), 32'h5);

        // Halt has priority over branch.
        fetch_in();
        retire(1'b1, 8'h02, 1'b0);
        fetch_in();
        retire(1'b1, 8'h33, 1'b1);
        chk("halt_flag", 32'(halted),    32'h1);
        chk("halt_pc",   32'(p_count),   32'h02);
        chk("halt_cnt",  32'(instr_cnt), 32'h7);
        ex_done = 1'b1; run_en = 1'b1; branch_taken = 1'b1; branch_addr = 8'h44;
        for (int i = 0; i < 3; i++) tick();
        ex_done = 1'b0; run_en = 1'b0; branch_taken = 1'b0;
        chk("hold_flag",  32'(halted),    32'h1);
        chk("hold_pc",    32'(p_count),   32'h02);
        chk("hold_cnt",   32'(instr_cnt), 32'h7);
        chk("hold_valid", 32'(ir_valid),  32'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("unhalt_flag", 32'(halted),    32'h0);
        chk("unhalt_pc",   32'(p_count),   32'h00);
        chk("unhalt_cnt",  32'(instr_cnt), 32'h0);

        // Reset while in LOAD aborts the capture.
        run_en = 1'b1;
        tick();
        run_en = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("rld_ir",    32'(ir),        32'h0);
        chk("rld_valid", 32'(ir_valid),  32'h0);
        chk("rld_pc",    32'(p_count),   32'h00);
        chk("rld_cnt",   32'(instr_cnt), 32'h0);
        reset = 1'b0;
        tick();
        chk("idle_valid", 32'(ir_valid), 32'h0);
        chk("idle_ir",    32'(ir),       32'h0);

        // Retire counter saturation.
        force dut.u_instr_cnt.cnt = 16'hFFFE;
        tick();
        release dut.u_instr_cnt.cnt;
        tick();
        chk("sat_pre", 32'(instr_cnt), 32'hFFFE);
        run_en = 1'b1;
        tick();
        run_en = 1'b0;
        tick();
        tick();
        retire(1'b0, 8'h00, 1'b0);
        chk("sat_1", 32'(instr_cnt), 32'hFFFF);
        fetch_in();
        retire(1'b0, 8'h00, 1'b0);
        chk("sat_2", 32'(instr_cnt), 32'hFFFF);
        fetch_in();
        retire(1'b0, 8'h00, 1'b0);
        chk("sat_3",    32'(instr_cnt), 32'hFFFF);
        chk("sat_pc",   32'(p_count),   32'h03);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
